// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC fetch from Imem into a 2-entry buffer for decode, with redirect/squash handling.
// FETCH_MISALIGN_EXC_EN: misaligned PC produces one exception entry and halts fetch until redirect or reset.
module fetch_unit #(
    parameter int                       ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0]  BOOT_ADDRESS = ADDRESS_SIZE'(32'h1000)
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [ADDRESS_SIZE-1:0] imem_address,
    output logic                    imem_req,
    input  logic                    imem_ready,
    input  logic [ADDRESS_SIZE-1:0] imem_instruction,
    output logic                    if_valid,
    output logic [ADDRESS_SIZE-1:0] if_pc,
    output logic [ADDRESS_SIZE-1:0] if_instruction,
    output logic                    if_exc,
    input  logic                    dec_ready,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc
);
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_REQ    = 3'd1,
        ST_SQUASH = 3'd2,
        ST_HOLD   = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [ADDRESS_SIZE-1:0] PC_STEP    = ADDRESS_SIZE'(4);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'(3);

    state_t                  state, state_nxt;
    logic [ADDRESS_SIZE-1:0] pc, pc_nxt, redirect_target;
    logic [1:0]              count;
    logic                    rd_ptr, wr_ptr;
    logic [ADDRESS_SIZE-1:0] buf_pc  [2];
    logic [ADDRESS_SIZE-1:0] buf_ins [2];
    logic                    push, pop, req_nxt;

`ifdef FETCH_MISALIGN_EXC_EN
    logic buf_exc [2];
    logic push_exc;
    assign redirect_target = redirect_pc;
    // A misaligned PC in REQ never issues a request; the exception entry is pushed instead.
    assign req_nxt = (state_nxt == ST_SQUASH) || ((state_nxt == ST_REQ) && (pc_nxt[1:0] == 2'b00));
    assign if_exc  = buf_exc[rd_ptr];
`else
    assign redirect_target = redirect_pc & ALIGN_MASK;
    assign req_nxt = (state_nxt == ST_SQUASH) || (state_nxt == ST_REQ);
    assign if_exc  = 1'b0;
`endif

    assign if_valid       = (count != 2'd0);
    assign if_pc          = buf_pc[rd_ptr];
    assign if_instruction = buf_ins[rd_ptr];
    assign pop            = if_valid && dec_ready;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
        push_exc  = 1'b0;
`endif
        case (state)
            ST_BOOT: state_nxt = ST_REQ;
            ST_REQ: begin
`ifdef FETCH_MISALIGN_EXC_EN
                if (pc[1:0] != 2'b00) begin
                    push      = 1'b1;
                    push_exc  = 1'b1;
                    state_nxt = ST_STOP;
                end else
`endif
                if (imem_ready) begin
                    push   = 1'b1;
                    pc_nxt = pc + PC_STEP;
                    // Hold off when this push leaves no free slot, net of a same-cycle pop.
                    if ((count == 2'd2) || ((count == 2'd1) && !pop))
                        state_nxt = ST_HOLD;
                end
            end
            ST_HOLD:   if (pop) state_nxt = ST_REQ;
            ST_SQUASH: if (imem_ready) state_nxt = ST_REQ;
            default:   state_nxt = state;
        endcase

        // A redirect arriving as the squashed response lands needs no further wait.
        if (redirect_valid) begin
            push   = 1'b0;
            pc_nxt = redirect_target;
            if ((((state == ST_REQ) && imem_req) || (state == ST_SQUASH)) && !imem_ready)
                state_nxt = ST_SQUASH;
            else
                state_nxt = ST_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_BOOT;
            pc           <= BOOT_ADDRESS;
            imem_req     <= 1'b0;
            imem_address <= BOOT_ADDRESS;
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]  <= '0;
                buf_ins[i] <= '0;
`ifdef FETCH_MISALIGN_EXC_EN
                buf_exc[i] <= 1'b0;
`endif
            end
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            imem_req <= req_nxt;
            if (state_nxt != ST_SQUASH)
                imem_address <= pc_nxt;
            if (redirect_valid) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    buf_pc[wr_ptr] <= pc;
`ifdef FETCH_MISALIGN_EXC_EN
                    buf_ins[wr_ptr] <= push_exc ? '0 : imem_instruction;
                    buf_exc[wr_ptr] <= push_exc;
`else
                    buf_ins[wr_ptr] <= imem_instruction;
`endif
                    wr_ptr <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed cycle tables plus randomized traffic against a stream-level model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, imem_ready, dec_ready, redirect_valid;
    logic [31:0] redirect_pc, imem_instruction, imem_address;
    logic        imem_req, if_valid, if_exc;
    logic [31:0] if_pc, if_instruction;

    always #5 clk = ~clk;

    fetch_unit #(.ADDRESS_SIZE(32), .BOOT_ADDRESS(32'h1000)) dut (
        .clk(clk), .reset(reset),
        .imem_address(imem_address), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_instruction(imem_instruction),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction), .if_exc(if_exc),
        .dec_ready(dec_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // chk: 0 = no check, 1 = request/valid (+head when valid), 2 = full reset state
    typedef struct {
        bit          rst, rdy, dec, rv;
        logic [31:0] rpc;
        int          chk;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
        bit          e_exc;
    } vec_t;
    vec_t vt[$];

    task automatic add(input int rst, input int rdy, input int dec, input int rv, input logic [31:0] rpc,
                       input int chk, input int e_req, input logic [31:0] e_addr,
                       input int e_vld, input logic [31:0] e_pc, input int e_exc);
        vec_t v;
        v.rst = (rst != 0); v.rdy = (rdy != 0); v.dec = (dec != 0); v.rv = (rv != 0);
        v.rpc = rpc; v.chk = chk; v.e_req = (e_req != 0); v.e_addr = e_addr;
        v.e_vld = (e_vld != 0); v.e_pc = e_pc; v.e_exc = (e_exc != 0);
        vt.push_back(v);
    endtask

    task automatic reset_pair(input int rdy, input int dec);
        add(1, 1, 1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
        add(0, rdy, dec, 0, 32'h0, 2, 0, 32'h1000, 0, 32'h0, 0);
    endtask

    logic [31:0] exp_pc, stop_pc, rp, tgt, prev_addr;
    bit          stopped, exc_pend, prev_rst, prev_hold;
    int          accepted;

    initial begin
        reset = 1'b1; imem_ready = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_instruction = 32'h0;

        // steady streaming after reset
        reset_pair(1, 1);
        add(0,1,1,0,32'h0, 1, 1,32'h1000, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h1004, 1,32'h1000, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h1008, 1,32'h1004, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h100C, 1,32'h1008, 0);
        // decode stalled: buffer fills, fetch holds, then drains and resumes
        reset_pair(1, 0);
        add(0,1,0,0,32'h0, 1, 1,32'h1000, 0,32'h0, 0);
        add(0,1,0,0,32'h0, 1, 1,32'h1004, 1,32'h1000, 0);
        add(0,1,0,0,32'h0, 1, 0,32'h0, 1,32'h1000, 0);
        add(0,1,0,0,32'h0, 1, 0,32'h0, 1,32'h1000, 0);
        add(0,1,0,0,32'h0, 1, 0,32'h0, 1,32'h1000, 0);
        add(0,1,1,0,32'h0, 1, 0,32'h0, 1,32'h1000, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h1008, 1,32'h1004, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h100C, 1,32'h1008, 0);
        // Imem stall at 0x1004
        reset_pair(1, 1);
        add(0,1,1,0,32'h0, 1, 1,32'h1000, 0,32'h0, 0);
        add(0,0,1,0,32'h0, 1, 1,32'h1004, 1,32'h1000, 0);
        add(0,0,1,0,32'h0, 1, 1,32'h1004, 0,32'h0, 0);
        add(0,0,1,0,32'h0, 1, 1,32'h1004, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h1004, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h1008, 1,32'h1004, 0);
        // redirect with 0x1008 outstanding: squash then fetch 0x2000
        reset_pair(1, 1);
        add(0,1,1,0,32'h0,    1, 1,32'h1000, 0,32'h0, 0);
        add(0,1,1,0,32'h0,    1, 1,32'h1004, 1,32'h1000, 0);
        add(0,0,1,1,32'h2000, 1, 1,32'h1008, 1,32'h1004, 0);
        add(0,0,1,0,32'h0,    1, 1,32'h1008, 0,32'h0, 0);
        add(0,1,1,0,32'h0,    1, 1,32'h1008, 0,32'h0, 0);
        add(0,1,1,0,32'h0,    1, 1,32'h2000, 0,32'h0, 0);
        add(0,1,1,0,32'h0,    1, 1,32'h2004, 1,32'h2000, 0);
        // misaligned redirect target
        reset_pair(1, 1);
        add(0,1,1,1,32'h2002, 1, 1,32'h1000, 0,32'h0, 0);
`ifdef FETCH_MISALIGN_EXC_EN
        add(0,1,1,0,32'h0, 1, 0,32'h0, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 0,32'h0, 1,32'h2002, 1);
        add(0,1,1,0,32'h0, 1, 0,32'h0, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 0,32'h0, 0,32'h0, 0);
`else
        add(0,1,1,0,32'h0, 1, 1,32'h2000, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h2004, 1,32'h2000, 0);
`endif
        // PC wraps past the top of the address space
        reset_pair(1, 1);
        add(0,1,1,1,32'hFFFF_FFFC, 1, 1,32'h1000, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 1,32'hFFFF_FFFC, 0,32'h0, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h0000_0000, 1,32'hFFFF_FFFC, 0);
        add(0,1,1,0,32'h0, 1, 1,32'h0000_0004, 1,32'h0000_0000, 0);
        // reset beats a same-cycle redirect and drops the outstanding fetch
        reset_pair(1, 1);
        add(0,1,1,0,32'h0,    1, 1,32'h1000, 0,32'h0, 0);
        add(0,0,1,0,32'h0,    1, 1,32'h1004, 1,32'h1000, 0);
        add(1,1,1,1,32'h3000, 1, 1,32'h1004, 0,32'h0, 0);
        add(0,1,1,0,32'h0,    2, 0,32'h1000, 0,32'h0, 0);
        add(0,1,1,0,32'h0,    1, 1,32'h1000, 0,32'h0, 0);

        @(posedge clk); #1;
        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; imem_ready = vt[i].rdy; dec_ready = vt[i].dec;
            redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc;
            imem_instruction = memf(imem_address);
            if (vt[i].chk != 0) begin
                check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vt[i].e_req));
                check($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vt[i].e_vld));
                if (vt[i].e_req || vt[i].chk == 2)
                    check($sformatf("v%0d imem_address", i), imem_address, vt[i].e_addr);
                if (vt[i].chk == 2) begin
                    check($sformatf("v%0d reset if_pc", i), if_pc, 32'h0);
                    check($sformatf("v%0d reset if_instruction", i), if_instruction, 32'h0);
                    check($sformatf("v%0d reset if_exc", i), 32'(if_exc), 32'h0);
                end else if (vt[i].e_vld) begin
                    check($sformatf("v%0d if_pc", i), if_pc, vt[i].e_pc);
                    check($sformatf("v%0d if_instruction", i), if_instruction,
                          vt[i].e_exc ? 32'h0 : memf(vt[i].e_pc));
                    check($sformatf("v%0d if_exc", i), 32'(if_exc), 32'(vt[i].e_exc));
                end
            end
            @(posedge clk); #1;
        end

        // randomized traffic: decoded stream must be the in-order PC sequence from the last redirect/reset
        reset = 1'b1; redirect_valid = 1'b0;
        @(posedge clk); #1;
        exp_pc = 32'h1000; stopped = 1'b0; exc_pend = 1'b0; stop_pc = 32'h0;
        prev_rst = 1'b1; prev_hold = 1'b0; prev_addr = 32'h0; accepted = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_rst) begin
                check("rnd post-reset imem_req", 32'(imem_req), 32'h0);
                check("rnd post-reset if_valid", 32'(if_valid), 32'h0);
            end else if (prev_hold) begin
                check("rnd held imem_req", 32'(imem_req), 32'h1);
                check("rnd held imem_address", imem_address, prev_addr);
            end else if (stopped) begin
                check("rnd stopped imem_req", 32'(imem_req), 32'h0);
            end

            reset          = ($urandom_range(0, 199) == 0);
            imem_ready     = ($urandom_range(0, 9) < 7);
            dec_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            redirect_pc      = rp;
            imem_instruction = memf(imem_address);

            if (reset) begin
                exp_pc = 32'h1000; stopped = 1'b0; exc_pend = 1'b0;
            end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_EXC_EN
                tgt = rp;
`else
                tgt = rp & 32'hFFFF_FFFC;
`endif
                exp_pc = tgt; stop_pc = tgt;
                stopped = (tgt[1:0] != 2'b00); exc_pend = stopped;
            end else if (if_valid && dec_ready) begin
                if (exc_pend) begin
                    check("rnd exc if_pc", if_pc, stop_pc);
                    check("rnd exc if_exc", 32'(if_exc), 32'h1);
                    exc_pend = 1'b0;
                end else if (stopped) begin
                    check("rnd entry while stopped", 32'(if_valid), 32'h0);
                end else begin
                    check("rnd if_pc", if_pc, exp_pc);
                    check("rnd if_instruction", if_instruction, memf(exp_pc));
                    check("rnd if_exc", 32'(if_exc), 32'h0);
                    exp_pc = exp_pc + 32'd4;
                    accepted++;
                end
            end
            prev_rst  = reset;
            prev_hold = imem_req && !imem_ready;
            prev_addr = imem_address;
            @(posedge clk); #1;
        end
        check("rnd accepted >500", 32'(accepted > 500), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
